// File: rtl/dram_arbiter.sv
// dram_arbiter: two-requester round-robin arbiter in front of a single-port synchronous memory.
// Latency: write ack two cycles after the request is seen in IDLE, read ack three cycles.
// Backpressure: a requester holds req until its ack; the loser waits, nothing is dropped.
module dram_arbiter #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [15:0] addr0,
  input  logic [7:0]  wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic        err,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_wren,
  input  logic [7:0]  mem_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t nxt_state;

  // Latched transaction; the latched address and write data live directly
  // in mem_address / mem_data since those must hold them anyway.
  logic owner;
  logic lat_we;
  logic lat_oor;
  logic last;

  logic        start;
  logic        win;
  logic        sel_we;
  logic        sel_oor;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic        nxt_owner;
  logic        nxt_we;
  logic        nxt_oor;
  logic        busy;

  assign sel_we    = win ? we1 : we0;
  assign sel_addr  = win ? addr1 : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;
  assign sel_oor   = (sel_addr >= 16'(DEPTH));

  // Outputs are registered from the upcoming state, so a fresh winner's
  // attributes are used on the edge that enters ISSUE.
  assign nxt_owner = start ? win : owner;
  assign nxt_we    = start ? sel_we : lat_we;
  assign nxt_oor   = start ? sel_oor : lat_oor;
  assign busy      = (nxt_state != IDLE);

  // State register; reset forces IDLE immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  // Next-state logic and round-robin choice of the winner in IDLE
  always_comb begin
    nxt_state = state;
    start     = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          start     = 1'b1;
          nxt_state = ISSUE;
          // Contention goes to whoever was not served last; a lone
          // requester wins regardless of history.
          win       = (req0 && req1) ? ~last : req1;
        end
      end
      ISSUE:   nxt_state = lat_we ? DONE : READ;
      READ:    nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Latch the winning request and register every output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner       <= 1'b0;
      lat_we      <= 1'b0;
      lat_oor     <= 1'b0;
      last        <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err         <= 1'b0;
      mem_wren    <= 1'b0;
      rdata       <= 8'h00;
      mem_address <= 16'h0000;
      mem_data    <= 8'h00;
    end else begin
      if (start) begin
        owner       <= win;
        lat_we      <= sel_we;
        lat_oor     <= sel_oor;
        mem_address <= sel_addr;
        mem_data    <= sel_wdata;
      end
      gnt0     <= busy && !nxt_owner;
      gnt1     <= busy && nxt_owner;
      ack0     <= (nxt_state == DONE) && !nxt_owner;
      ack1     <= (nxt_state == DONE) && nxt_owner;
      err      <= (nxt_state == DONE) && nxt_oor;
      // Out-of-range writes never reach the memory
      mem_wren <= (nxt_state == ISSUE) && nxt_we && !nxt_oor;
      // mem_q reflects the address presented during ISSUE
      if (state == READ) begin
        rdata <= lat_oor ? 8'h00 : mem_q;
      end
      if (state == DONE) begin
        last <= owner;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed table, hand sequences and randomized run against a timeline model.
module tb_dram_arbiter;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = 16'd0, addr1 = 16'd0;
  logic [7:0]  wdata0 = 8'd0, wdata1 = 8'd0;
  logic        gnt0, gnt1, ack0, ack1, err, mem_wren;
  logic [7:0]  rdata, mem_data, mem_q;
  logic [15:0] mem_address;

  int total = 0;
  int bad   = 0;

  // Memory environment: synchronous write, one-cycle registered read
  logic [7:0] mem [0:7];
  logic       mem_init = 1'b1;

  always #5 clock = ~clock;

  dram_arbiter #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .err(err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h20 + 8'(i);
    end else if (mem_wren && mem_address < 16'd8) begin
      mem[mem_address[2:0]] <= mem_data;
    end
    mem_q <= (mem_address < 16'd8) ? mem[mem_address[2:0]] : 8'hEE;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Exclusivity invariants sampled every cycle away from the edge
  always @(negedge clock) begin
    if (!reset) begin
      check("one_gnt", 64'(gnt0 & gnt1), 64'd0);
      check("one_ack", 64'(ack0 & ack1), 64'd0);
      check("ack_without_gnt", 64'((ack0 & !gnt0) | (ack1 & !gnt1)), 64'd0);
    end
  end

  task automatic do_reset();
    reset = 1'b1; mem_init = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'd0; addr1 = 16'd0; wdata0 = 8'd0; wdata1 = 8'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    mem_init = 1'b0; reset = 1'b0;
  endtask

  function automatic logic [37:0] outs();
    return {gnt0, gnt1, ack0, ack1, err, mem_wren, rdata, mem_address, mem_data};
  endfunction

  typedef struct {
    bit          who;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[12];

  // One transaction from an idle arbiter; returns with the arbiter idle again
  task automatic run_vec(input vec_t v, input int idx);
    int   lat = 0;
    int   wren_cnt = 0;
    bit   gnt_ok = 1'b1;
    bit   seen = 1'b0;
    logic [7:0] rd = 8'hxx;
    logic er = 1'bx;
    if (v.who) begin req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    else       begin req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    for (int n = 1; n <= 8 && !seen; n++) begin
      @(posedge clock); #1;
      if (mem_wren) wren_cnt++;
      if (!(v.who ? gnt1 : gnt0) || (v.who ? gnt0 : gnt1)) gnt_ok = 1'b0;
      if (v.who ? ack1 : ack0) begin seen = 1'b1; lat = n; rd = rdata; er = err; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(v.lat));
    check($sformatf("vec%0d_gnt", idx), 64'(gnt_ok), 64'd1);
    check($sformatf("vec%0d_wren_cycles", idx), 64'(wren_cnt),
          64'((v.we && v.addr < 16'(DEPTH)) ? 1 : 0));
    check($sformatf("vec%0d_rdata", idx), 64'(rd), 64'(v.exp_rdata));
    check($sformatf("vec%0d_err", idx), 64'(er), 64'(v.exp_err));
    @(posedge clock); #1;
  endtask

  // Timeline reference model for the randomized phase
  bit          m_act, m_own, m_we, m_oor, m_last;
  int          m_s, m_len;
  logic [15:0] m_addr;
  logic [7:0]  m_data, m_rd;
  logic [7:0]  exp_mem [0:7];

  task automatic model_step(input int p);
    int d;
    if (m_act && (p - m_s) >= m_len) begin
      m_act = 1'b0;
    end else if (!m_act && (req0 || req1)) begin
      m_own  = (req0 && req1) ? !m_last : req1;
      m_last = m_own;
      m_act  = 1'b1;
      m_s    = p;
      m_we   = m_own ? we1 : we0;
      m_addr = m_own ? addr1 : addr0;
      m_data = m_own ? wdata1 : wdata0;
      m_oor  = (m_addr >= 16'(DEPTH));
      m_len  = m_we ? 2 : 3;
    end
    if (m_act) begin
      d = p - m_s;
      if (m_we && d == 1 && !m_oor) exp_mem[m_addr[2:0]] = m_data;
      if (!m_we && d == 2) m_rd = m_oor ? 8'h00 : exp_mem[m_addr[2:0]];
    end
  endtask

  function automatic logic [37:0] model_outs(input int p);
    int d;
    bit g, a;
    d = p - m_s;
    g = m_act;
    a = m_act && (d == m_len - 1);
    return {g && !m_own, g && m_own, a && !m_own, a && m_own, a && m_oor,
            m_act && d == 0 && m_we && !m_oor, m_rd, m_addr, m_data};
  endfunction

  initial begin
    int got;
    int acks;
    bit first_seen;

    vecs[0]  = '{1'b0, 1'b1, 16'd3,     8'h5A, 2, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'd3,     8'h00, 3, 8'h5A, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'd7,     8'hC3, 2, 8'h5A, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'd7,     8'h00, 3, 8'hC3, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'd8,     8'hFF, 2, 8'hC3, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 16'd8,     8'h00, 3, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 16'd0,     8'h00, 3, 8'h20, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 16'd0,     8'hA5, 2, 8'h20, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'd0,     8'h00, 3, 8'hA5, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'd6,     8'h00, 3, 8'h26, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 16'hFFFF,  8'h77, 2, 8'h26, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 16'd2,     8'h00, 3, 8'h22, 1'b0};

    do_reset();
    check("reset_outputs", 64'(outs()), 64'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Contention: both reading continuously; requester 1 was served last
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd2;
    got = 0;
    for (int n = 0; n < 40 && got < 6; n++) begin
      @(posedge clock); #1;
      if (ack0 || ack1) begin
        check($sformatf("contend_order%0d", got), 64'(ack1), 64'(got % 2));
        check($sformatf("contend_rdata%0d", got), 64'(rdata), ack1 ? 64'h22 : 64'h21);
        got++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("contend_ack_count", 64'(got), 64'd6);
    @(posedge clock); #1;

    // Address changes during READ do not affect the latched transaction
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd2;
    repeat (2) begin @(posedge clock); #1; end
    check("midchg_addr_held", 64'(mem_address), 64'd2);
    addr1 = 16'd5;
    @(posedge clock); #1;
    check("midchg_ack", 64'(ack1), 64'd1);
    check("midchg_rdata", 64'(rdata), 64'h22);
    req1 = 1'b0;
    @(posedge clock); #1;

    // Back-to-back: req1 held through DONE gets one IDLE cycle then a new grant
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd4;
    repeat (3) begin @(posedge clock); #1; end
    check("b2b_first_ack", 64'({ack1, rdata}), 64'({1'b1, 8'h24}));
    addr1 = 16'd3;
    @(posedge clock); #1;
    check("b2b_idle_gap", 64'({gnt1, ack1}), 64'd0);
    @(posedge clock); #1;
    check("b2b_regrant", 64'(gnt1), 64'd1);
    repeat (2) begin @(posedge clock); #1; end
    check("b2b_second_ack", 64'({ack1, rdata}), 64'({1'b1, 8'h5A}));
    req1 = 1'b0;
    @(posedge clock); #1;

    // Reset while a write is in ISSUE
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd1; wdata0 = 8'h11;
    @(posedge clock); #1;
    check("rst_issue_wren_before", 64'({gnt0, mem_wren}), 64'd3);
    #2 reset = 1'b1;
    #1 check("rst_issue_wren_dropped", 64'({gnt0, mem_wren}), 64'd0);
    req0 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clock); #1;
      if (ack0 || ack1) acks++;
    end
    check("rst_no_ack", 64'(acks), 64'd0);
    check("rst_mem_unchanged", 64'(mem[1]), 64'h21);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd1;
    first_seen = 1'b0;
    for (int n = 0; n < 10 && !first_seen; n++) begin
      @(posedge clock); #1;
      if (ack0 || ack1) begin
        first_seen = 1'b1;
        check("rst_first_winner", 64'({ack0, ack1, rdata}), 64'({2'b10, 8'h21}));
      end
    end
    check("rst_first_ack_seen", 64'(first_seen), 64'd1);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clock); #1;

    // Randomized traffic against the timeline model
    do_reset();
    check("rand_reset_outputs", 64'(outs()), 64'd0);
    m_act = 1'b0; m_last = 1'b1; m_own = 1'b0; m_we = 1'b0; m_oor = 1'b0;
    m_s = 0; m_len = 2; m_addr = 16'd0; m_data = 8'd0; m_rd = 8'd0;
    for (int i = 0; i < 8; i++) exp_mem[i] = 8'h20 + 8'(i);
    for (int p = 1; p <= 1500; p++) begin
      if (req0 && ack0) req0 = ($urandom_range(0, 3) == 0);
      else if (!req0)   req0 = ($urandom_range(0, 2) == 0);
      if (req1 && ack1) req1 = ($urandom_range(0, 3) == 0);
      else if (!req1)   req1 = ($urandom_range(0, 2) == 0);
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      addr0 = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
      addr1 = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      @(posedge clock);
      model_step(p);
      #1;
      check($sformatf("rand_cycle%0d", p), 64'(outs()), 64'(model_outs(p)));
      @(negedge clock);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter: DEPTH, 8, number of valid memory locations; addresses >= DEPTH are out of range.
REQ-002 Port: clock  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: req0  in  1  requester 0 transaction request; held high until ack0.
REQ-005 Port: we0  in  1  requester 0 direction (1 = write, 0 = read).
REQ-006 Port: addr0  in  16  requester 0 byte address.
REQ-007 Port: wdata0  in  8  requester 0 write data.
REQ-008 Port: req1, we1, addr1, wdata1  in  1/1/16/8  requester 1, same meaning as requester 0.
REQ-009 Port: gnt0, gnt1  out  1 each  requester owns the memory; high from ISSUE through DONE inclusive.
REQ-010 Port: ack0, ack1  out  1 each  one-cycle transaction-complete pulse.
REQ-011 Port: rdata  out  8  read result; valid while ackN is high; holds its value until the next read completes.
REQ-012 Port: err  out  1  one-cycle pulse with ackN when the address was out of range.
REQ-013 Port: mem_address  out  16  drives memory address.
REQ-014 Port: mem_data  out  8  drives memory write data.
REQ-015 Port: mem_wren  out  1  memory write enable (1 = write, 0 = read).
REQ-016 Port: mem_q  in  8  memory read data; valid one clock after the address edge.

Function
REQ-017 States: IDLE, ISSUE, READ, DONE; all outputs driven from registers.
REQ-018 IDLE: when no req is high, stay in IDLE, with all gnt/ack/err low and mem_wren low.
REQ-019 IDLE with any req high: latch the winner's id, we, addr and wdata; go to ISSUE next edge.
REQ-020 Arbitration is round-robin: if both requesters request, the requester not served last wins; after reset requester 0 has priority.
REQ-021 A single requesting requester wins regardless of round-robin history.
REQ-022 ISSUE: mem_address = latched addr and mem_data = latched wdata.
REQ-023 ISSUE: mem_wren = latched we AND (addr < DEPTH); mem_wren is high in no other state.
REQ-024 ISSUE: the next state is DONE for a write and READ for a read.
REQ-025 READ: mem_address is held; rdata <= mem_q at the end of the cycle, or rdata <= 8'h00 if out of range; go to DONE.
REQ-026 DONE: ackN of the owner is high for exactly one cycle; err is high if out of range.
REQ-027 DONE: the last-served pointer is updated to the owner, and the next state is IDLE.
REQ-028 Latency from the edge on which the request is sampled: write ack 2 cycles later; read ack 3 cycles later.
REQ-029 Requests are not pre-empted or aborted; deasserting req, or changing we/addr/wdata, after the IDLE sample has no effect on the current transaction.
REQ-030 A req still high in DONE is re-arbitrated in the following IDLE cycle, so each transaction takes at least one IDLE cycle.
REQ-031 At most one gnt and at most one ack are high in any cycle; ack is never asserted for a requester without its gnt.
REQ-032 Out-of-range write: no memory write occurs, ack is still returned, and err pulses.
REQ-033 An address equal to DEPTH-1 is in range; an address equal to DEPTH is out of range.

Reset
REQ-034 Asserting reset forces state IDLE immediately, independent of clock.
REQ-035 Reset values: gnt0/1, ack0/1, err, mem_wren = 0; rdata, mem_address, mem_data = 0; last-served pointer = requester 1, so requester 0 wins first.
REQ-036 Reset during ISSUE of a write drops mem_wren at once; no acknowledgement is issued for the aborted transaction.
REQ-037 After reset deasserts, the first rising edge with a req high starts arbitration normally.

Verification
REQ-038 Write then read, requester 0 only: write addr 3, data 8'h5A -> ack0 2 cycles after sample; then read addr 3 -> ack0 3 cycles after sample with rdata = 8'h5A and err = 0.
REQ-039 Contention: req0 and req1 both high continuously, all reads -> grants alternate 0,1,0,1; no overlapping gnt; each ack matches its gnt.
REQ-040 Range boundary: read addr 7 returns stored byte with err = 0; write addr 8 with data 8'hFF -> mem_wren never high, err pulses with ack, memory unchanged.
REQ-041 Mid-transaction change: requester 1 changes addr from 2 to 5 during READ -> rdata reflects addr 2.
REQ-042 Reset in ISSUE of a write to addr 1 with data 8'h11 -> mem_wren = 0 immediately; no ack; memory addr 1 keeps its prior value; next grant goes to requester 0.
REQ-043 Back-to-back: requester 1 keeps req1 high through DONE -> one IDLE cycle, then re-granted if req0 is low.
